dds_wavetable_dbuf: RTL
=======================

# dds_wavetable_dbuf

- Double-buffered, parametrised DDS waveform table with an integrated phase accumulator.
- The Nios II writes a new waveform into a shadow bank over Avalon-MM while the DDS keeps reading the active bank.
- A software swap request switches banks only at a phase wrap, so the output never shows a torn waveform.
- One instance per DDS channel sits between the processor interconnect and the DAC sample path.

## Interface
Parameters:
- DATA_W, 16: sample width; 1..32.
- ADDR_W, 10: table index width; depth per bank = 2^ADDR_W.
- PHASE_W, 32: phase accumulator width; must be >= ADDR_W and <= 32.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- avs_address  in  ADDR_W+1  MSB=0: table word in shadow bank; MSB=1: register index in low 2 bits.
- avs_write  in  1  write strobe.
- avs_read  in  1  read strobe.
- avs_writedata  in  32  write data; table writes use bits [DATA_W-1:0].
- avs_readdata  out  32  read data, readLatency 1, zero-extended.
- sample_out  out  DATA_W  current table sample.
- sample_valid  out  1  high while sample_out is from an enabled accumulator.
- wrap  out  1  one-cycle pulse on accumulator carry-out.

## Operation
Registers (MSB=1):
- 0 CTRL:
  - bit0 ENABLE (R/W).
  - bit1 SWAP_REQ (write-1 sets pending; reads 0).
  - bit2 PHASE_CLR (write-1 zeroes the phase next cycle; reads 0).
- 1 PHASE_INC: R/W, [PHASE_W-1:0].
- 2 STATUS: RO. bit0 SWAP_PENDING, bit1 ACTIVE_BANK.
- 3: reads 0; writes are ignored.

Table access:
- Writes land at {~ACTIVE_BANK, addr}.
- Reads return the shadow-bank word.
- The active bank is never CPU-accessible.

Accumulator:
- When ENABLE=1: phase <= phase + PHASE_INC, modulo 2^PHASE_W. Carry out raises `wrap`.
- Table index = phase[PHASE_W-1 -: ADDR_W]. DDS port reads {ACTIVE_BANK, index}.

Bank-swap FSM, states IDLE and PENDING:
- IDLE -> PENDING: SWAP_REQ written.
- PENDING -> IDLE at the first carry after the request cycle. ACTIVE_BANK toggles on the same edge as the wrapped phase load.
- PENDING -> IDLE immediately on the next edge if ENABLE=0.
- SWAP_REQ while PENDING: no effect; no double toggle.

Boundary rules:
- Carry in the same cycle as the SWAP_REQ write does not swap; the swap waits for the next wrap.
- PHASE_CLR together with a carry: clear wins; the swap still occurs if PENDING.
- PHASE_INC=0 with ENABLE=1: no wrap, so the swap stays pending until ENABLE is cleared.
- Table writes while PENDING go to the shadow bank. Software must poll SWAP_PENDING=0 before refilling.

Reset values (reset_n low):
- phase=0, PHASE_INC=0, ENABLE=0, ACTIVE_BANK=0, state IDLE.
- sample_out=0, sample_valid=0, wrap=0, avs_readdata=0.
- RAM contents are not reset.

## Timing
- Avalon: no waitrequest. Writes take effect at the strobe edge. avs_readdata is valid the cycle after avs_read.
- The phase register value P at cycle n produces sample_out = table[bank][idx(P)] at cycle n+2: one cycle registered RAM read, one output register.
- sample_valid follows ENABLE with the same 2-cycle delay.
- wrap is asserted in the cycle the wrapped phase is present, aligned to the phase register, not to sample_out.
- The first sample from the new bank appears 2 cycles after the wrap pulse.
- A CPU write and a DDS read of the same physical word cannot collide, because the banks differ.

## Structure
- Shared package dds_pkg holds:
  - register index constants: REG_CTRL, REG_INC, REG_STATUS;
  - CTRL/STATUS bit positions;
  - the swap-state enum.
- Sub-module dds_tdp_ram: single-clock true dual-port RAM, depth 2^(ADDR_W+1), width DATA_W, registered read on both ports, read-during-write don't-care.
- The FSM, accumulator and Avalon decode live in the top module.

## Test plan
1. Reset, then read STATUS and CTRL -> both 0; sample_out=0; sample_valid=0.
2. Fill shadow with table[i]=i, SWAP_REQ with ENABLE=0 -> ACTIVE_BANK=1 next cycle. Then PHASE_INC=2^22 (ADDR_W=10, PHASE_W=32), ENABLE=1 -> sample_out steps 0,1,2,…,1023, wrap pulse, 0; first sample 2 cycles after ENABLE write.
3. Running with bank1=ramp, bank0=constant 0x7FFF, SWAP_REQ mid-period -> STATUS.bit0=1 until wrap. sample_out stays ramp until 2 cycles after wrap, then 0x7FFF.
4. SWAP_REQ written in the exact carry cycle -> no swap at that wrap; swap at the following wrap.
5. PHASE_INC=0, ENABLE=1, SWAP_REQ -> remains pending. Clear ENABLE -> swaps next cycle. A second SWAP_REQ while pending -> single toggle.
6. Assert reset_n low mid-run with swap pending -> all registers at reset values next edge. Table reads return previously written data.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants and types for the double-buffered DDS wavetable:
// register map, CTRL/STATUS bit positions and the bank-swap state encoding.
package dds_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_INC    = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;

   localparam int CTRL_ENABLE_BIT    = 0;
   localparam int CTRL_SWAP_BIT      = 1;
   localparam int CTRL_CLR_BIT       = 2;

   localparam int STATUS_PENDING_BIT = 0;
   localparam int STATUS_BANK_BIT    = 1;

   typedef enum logic {
      SWAP_IDLE    = 1'b0,
      SWAP_PENDING = 1'b1
   } swap_state_t;

endpackage

// File: rtl/dds_tdp_ram.sv
// Single-clock true dual-port RAM with registered reads on both ports.
// Read-during-write on the same address returns unspecified data.
module dds_tdp_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] a_rdata_reg;
   logic [DATA_W-1:0] b_rdata_reg;

   // Both ports share one process so the array has a single driver.
   always_ff @(posedge clk) begin
      if (a_we) begin
         mem[a_addr] <= a_wdata;
      end
      if (b_we) begin
         mem[b_addr] <= b_wdata;
      end
      a_rdata_reg <= mem[a_addr];
      b_rdata_reg <= mem[b_addr];
   end

   assign a_rdata = a_rdata_reg;
   assign b_rdata = b_rdata_reg;

endmodule

// File: rtl/dds_wavetable_dbuf.sv
// DDS channel: phase accumulator reading the active wavetable bank while the
// CPU fills the shadow bank over Avalon-MM; bank swaps happen only at a wrap.
module dds_wavetable_dbuf
   import dds_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 10,
   parameter int PHASE_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W:0]   avs_address,
   input  logic              avs_write,
   input  logic              avs_read,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_valid,
   output logic              wrap
);

   swap_state_t        state_reg, state_next;
   logic [PHASE_W-1:0] phase_reg, phase_next;
   logic [PHASE_W-1:0] inc_reg;
   logic [PHASE_W:0]   phase_sum;
   logic               enable_reg;
   logic               bank_reg;
   logic               bank_toggle;
   logic               wrap_reg;
   logic               carry;
   logic               en_d1_reg, valid_reg;
   logic [DATA_W-1:0]  sample_reg;
   logic [DATA_W-1:0]  cpu_rdata, dds_rdata;
   logic               ram_sel_reg;
   logic [31:0]        reg_rd_reg, reg_rd_next;

   logic               reg_sel, tbl_wr, ctrl_wr, inc_wr;
   logic               swap_req, phase_clr;
   logic [1:0]         reg_idx;

   assign reg_sel   = avs_address[ADDR_W];
   assign reg_idx   = avs_address[1:0];
   assign tbl_wr    = avs_write & ~reg_sel;
   assign ctrl_wr   = avs_write & reg_sel & (reg_idx == REG_CTRL);
   assign inc_wr    = avs_write & reg_sel & (reg_idx == REG_INC);
   assign swap_req  = ctrl_wr & avs_writedata[CTRL_SWAP_BIT];
   assign phase_clr = ctrl_wr & avs_writedata[CTRL_CLR_BIT];

   assign phase_sum = {1'b0, phase_reg} + {1'b0, inc_reg};
   assign carry     = enable_reg & phase_sum[PHASE_W];

   // A request is only seen in IDLE, so a carry on the request edge is ignored
   // and repeated requests while PENDING cannot cause a second toggle.
   always_comb begin
      state_next  = state_reg;
      bank_toggle = 1'b0;
      case (state_reg)
         SWAP_IDLE: begin
            if (swap_req) begin
               state_next = SWAP_PENDING;
            end
         end
         SWAP_PENDING: begin
            if (!enable_reg || carry) begin
               state_next  = SWAP_IDLE;
               bank_toggle = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      phase_next = phase_reg;
      if (phase_clr) begin
         phase_next = '0;
      end else if (enable_reg) begin
         phase_next = phase_sum[PHASE_W-1:0];
      end
   end

   always_comb begin
      reg_rd_next = '0;
      case (reg_idx)
         REG_CTRL:   reg_rd_next[CTRL_ENABLE_BIT] = enable_reg;
         REG_INC:    reg_rd_next[PHASE_W-1:0]     = inc_reg;
         REG_STATUS: begin
            reg_rd_next[STATUS_PENDING_BIT] = (state_reg == SWAP_PENDING);
            reg_rd_next[STATUS_BANK_BIT]    = bank_reg;
         end
         default:    reg_rd_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg   <= SWAP_IDLE;
         phase_reg   <= '0;
         inc_reg     <= '0;
         enable_reg  <= 1'b0;
         bank_reg    <= 1'b0;
         wrap_reg    <= 1'b0;
         en_d1_reg   <= 1'b0;
         valid_reg   <= 1'b0;
         sample_reg  <= '0;
         ram_sel_reg <= 1'b0;
         reg_rd_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         phase_reg   <= phase_next;
         if (inc_wr) begin
            inc_reg <= avs_writedata[PHASE_W-1:0];
         end
         if (ctrl_wr) begin
            enable_reg <= avs_writedata[CTRL_ENABLE_BIT];
         end
         if (bank_toggle) begin
            bank_reg <= ~bank_reg;
         end
         wrap_reg    <= carry;
         en_d1_reg   <= enable_reg;
         valid_reg   <= en_d1_reg;
         sample_reg  <= dds_rdata;
         ram_sel_reg <= avs_read & ~reg_sel;
         reg_rd_reg  <= (avs_read & reg_sel) ? reg_rd_next : '0;
      end
   end

   always_comb begin
      avs_readdata = reg_rd_reg;
      if (ram_sel_reg) begin
         avs_readdata                = '0;
         avs_readdata[DATA_W-1:0]    = cpu_rdata;
      end
   end

   assign sample_out   = sample_reg;
   assign sample_valid = valid_reg;
   assign wrap         = wrap_reg;

   // Port A is the CPU side (always the shadow bank), port B the DDS side.
   dds_tdp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W + 1)
   ) u_ram (
      .clk     (clk),
      .a_we    (tbl_wr),
      .a_addr  ({~bank_reg, avs_address[ADDR_W-1:0]}),
      .a_wdata (avs_writedata[DATA_W-1:0]),
      .a_rdata (cpu_rdata),
      .b_we    (1'b0),
      .b_addr  ({bank_reg, phase_reg[PHASE_W-1 -: ADDR_W]}),
      .b_wdata ({DATA_W{1'b0}}),
      .b_rdata (dds_rdata)
   );

endmodule
